rvvi_depacketizer: RTL and testbench

Receive-side counterpart of the RVVI trace packetizer. It consumes Ethernet frames from the MAC's 32-bit AXI-stream RX port and strips the 14-byte Ethernet header. It filters on EtherType and reassembles the payload into one full-width rvvi trace record, which it presents on a valid/ready interface. It sits on the checker/host-side FPGA between the Ethernet MAC RX FIFO and the trace-comparison logic.

---
 rtl/rvvi_depacketizer.sv | 181 ++++++++++++++++++
 tb/tb_rvvi_depacketizer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_depacketizer.sv
// Receive-side RVVI trace depacketizer: strips the Ethernet header, filters on EtherType and
// reassembles the payload into one rvvi record presented on a valid/ready interface.
module rvvi_depacketizer #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned MAX_CSRS   = 5,
   parameter logic [15:0] ETHER_TYPE = 16'h88B5,
   localparam int unsigned RVVI_W     = 72 + 5*XLEN + MAX_CSRS*(XLEN+16),
   localparam int unsigned RVVI_BYTES = (RVVI_W + 7) / 8
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,
   input  logic [31:0]       RvviAxiRdata,
   input  logic [3:0]        RvviAxiRstrb,
   input  logic              RvviAxiRlast,
   input  logic              RvviAxiRvalid,
   output logic              RvviAxiRready,
   output logic [RVVI_W-1:0] rvvi,
   output logic              valid,
   input  logic              ready,
   output logic              FrameDrop,
   output logic [31:0]       GoodFrames,
   output logic [31:0]       BadFrames
);

   localparam int unsigned CntW = $clog2(RVVI_BYTES + 8);
   localparam logic [CntW:0] ByteLim = (CntW+1)'(RVVI_BYTES);
   localparam logic [CntW:0] SatLim  = (CntW+1)'(RVVI_BYTES + 3);

   typedef enum logic [2:0] {StIdle, StHdr, StType, StPayload, StDrain, StHold} state_e;

   state_e                  state_q, state_d;
   logic [1:0]              hdr_q, hdr_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [RVVI_BYTES*8-1:0] shadow_q, shadow_d;
   logic [RVVI_W-1:0]       rvvi_q, rvvi_d;
   logic [31:0]             good_q, good_d, bad_q, bad_d;
   logic                    drop_q, drop_d;
   logic                    badf_q, badf_d;

   logic            beat_ok, strb_bad, bad_evt;
   logic [CntW:0]   idx, sum;

   assign RvviAxiRready = (state_q != StHold);
   assign beat_ok       = RvviAxiRvalid & RvviAxiRready;

   always_comb begin
      if (RvviAxiRlast) begin
         strb_bad = !((RvviAxiRstrb == 4'b0001) || (RvviAxiRstrb == 4'b0011) ||
                      (RvviAxiRstrb == 4'b0111) || (RvviAxiRstrb == 4'b1111));
      end else begin
         strb_bad = (RvviAxiRstrb != 4'b1111);
      end
   end

   always_comb begin
      state_d  = state_q;
      hdr_d    = hdr_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      rvvi_d   = rvvi_q;
      good_d   = good_q;
      bad_d    = bad_q;
      drop_d   = 1'b0;
      badf_d   = badf_q;
      bad_evt  = 1'b0;
      idx      = '0;
      sum      = '0;

      if (state_q == StHold) begin
         if (ready) begin
            state_d = StIdle;
            good_d  = good_q + 32'd1;
         end
      end else if (beat_ok) begin
         // Strobe violations are only policed while the frame may still become a record.
         if (state_q != StDrain && strb_bad) begin
            if (RvviAxiRlast) begin
               bad_evt = 1'b1;
            end else begin
               badf_d  = 1'b1;
               state_d = StDrain;
            end
         end else begin
            case (state_q)
               StIdle: begin
                  if (RvviAxiRlast) begin
                     bad_evt = 1'b1;
                  end else begin
                     hdr_d   = 2'd1;
                     state_d = StHdr;
                  end
               end
               StHdr: begin
                  if (RvviAxiRlast) begin
                     bad_evt = 1'b1;
                  end else if (hdr_q == 2'd2) begin
                     state_d = StType;
                  end else begin
                     hdr_d = hdr_q + 2'd1;
                  end
               end
               StType: begin
                  if (RvviAxiRdata[15:0] != ETHER_TYPE) begin
                     state_d = RvviAxiRlast ? StIdle : StDrain;
                  end else if (RvviAxiRlast) begin
                     bad_evt = 1'b1;
                  end else begin
                     shadow_d[15:0] = RvviAxiRdata[31:16];
                     cnt_d          = CntW'(2);
                     state_d        = StPayload;
                  end
               end
               StPayload: begin
                  for (int l = 0; l < 4; l++) begin
                     idx = {1'b0, cnt_q} + (CntW+1)'(l);
                     if (RvviAxiRstrb[l] && (idx < ByteLim)) begin
                        shadow_d[8*idx +: 8] = RvviAxiRdata[8*l +: 8];
                     end
                  end
                  sum   = {1'b0, cnt_q} + (CntW+1)'($countones(RvviAxiRstrb));
                  cnt_d = (sum > SatLim) ? SatLim[CntW-1:0] : sum[CntW-1:0];
                  if (RvviAxiRlast) begin
                     if (sum >= ByteLim) begin
                        state_d = StHold;
                        rvvi_d  = shadow_d[RVVI_W-1:0];
                     end else begin
                        bad_evt = 1'b1;
                     end
                  end
               end
               StDrain: begin
                  if (RvviAxiRlast) begin
                     bad_evt = badf_q;
                     badf_d  = 1'b0;
                     state_d = StIdle;
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end

      if (bad_evt) begin
         bad_d   = bad_q + 32'd1;
         drop_d  = 1'b1;
         badf_d  = 1'b0;
         state_d = StIdle;
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q  <= StIdle;
         hdr_q    <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         rvvi_q   <= '0;
         good_q   <= '0;
         bad_q    <= '0;
         drop_q   <= 1'b0;
         badf_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hdr_q    <= hdr_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         rvvi_q   <= rvvi_d;
         good_q   <= good_d;
         bad_q    <= bad_d;
         drop_q   <= drop_d;
         badf_q   <= badf_d;
      end
   end

   assign rvvi       = rvvi_q;
   assign valid      = (state_q == StHold);
   assign FrameDrop  = drop_q;
   assign GoodFrames = good_q;
   assign BadFrames  = bad_q;

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed + randomized bench for rvvi_depacketizer; frames are byte queues judged by a
// frame-level reference model (type, length, strobe legality).
module tb_rvvi_depacketizer;

   localparam int XLEN = 64;
   localparam int MAXC = 5;
   localparam int RW   = 72 + 5*XLEN + MAXC*(XLEN+16);
   localparam int NB   = (RW + 7) / 8;
   localparam int GOOD = 1, BAD = 2, SILENT = 0;

   logic          clk = 1'b0;
   logic          s_axi_aresetn;
   logic [31:0]   RvviAxiRdata;
   logic [3:0]    RvviAxiRstrb;
   logic          RvviAxiRlast, RvviAxiRvalid, RvviAxiRready;
   logic [RW-1:0] rvvi;
   logic          valid, ready, FrameDrop;
   logic [31:0]   GoodFrames, BadFrames;

   rvvi_depacketizer #(.XLEN(XLEN), .MAX_CSRS(MAXC), .ETHER_TYPE(16'h88B5)) dut (
      .s_axi_aclk   (clk),
      .s_axi_aresetn(s_axi_aresetn),
      .RvviAxiRdata (RvviAxiRdata),
      .RvviAxiRstrb (RvviAxiRstrb),
      .RvviAxiRlast (RvviAxiRlast),
      .RvviAxiRvalid(RvviAxiRvalid),
      .RvviAxiRready(RvviAxiRready),
      .rvvi         (rvvi),
      .valid        (valid),
      .ready        (ready),
      .FrameDrop    (FrameDrop),
      .GoodFrames   (GoodFrames),
      .BadFrames    (BadFrames)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int drop_cnt = 0, rec_wr = 0, rec_rd = 0;
   int exp_good = 0, exp_bad = 0, exp_drop = 0, exp_nrec = 0;
   logic [RW-1:0] rec_mem [64];
   logic [RW-1:0] exp_mem [64];
   logic [RW-1:0] last_rec = '0;
   logic [RW-1:0] snap;
   logic [7:0]    frm[$];

   always @(negedge clk) begin
      if (FrameDrop) drop_cnt <= drop_cnt + 1;
      if (valid && ready) begin
         rec_mem[rec_wr % 64] <= rvvi;
         rec_wr               <= rec_wr + 1;
      end
   end

   task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // kind 0: matching type, 1: trigger type 005C, 2: random non-matching type
   task automatic gen(input int n, input int kind);
      frm.delete();
      for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
      if (n >= 14) begin
         if (kind == 0) begin
            frm[12] = 8'hB5; frm[13] = 8'h88;
         end else if (kind == 1) begin
            frm[12] = 8'h5C; frm[13] = 8'h00;
         end else if ({frm[13], frm[12]} == 16'h88B5) begin
            frm[12] = 8'h00;
         end
      end
   endtask

   // Frame-level judgement: runt, EtherType filter, record length, strobe legality.
   task automatic model_frame(input int bad_beat);
      int n, nbeats, res;
      logic [15:0] et;
      logic [RW-1:0] rec;
      n      = frm.size();
      nbeats = (n + 3) / 4;
      et     = (n >= 14) ? {frm[13], frm[12]} : (n == 13) ? {8'h00, frm[12]} : 16'h0;
      if (bad_beat >= 0 && bad_beat < nbeats - 1 && (bad_beat <= 3 || et == 16'h88B5)) res = BAD;
      else if (n <= 12)          res = BAD;
      else if (et != 16'h88B5)   res = SILENT;
      else if (n - 14 >= NB)     res = GOOD;
      else                       res = BAD;
      if (res == GOOD) begin
         rec = '0;
         for (int k = 0; k < NB; k++) rec[8*k +: 8] = frm[14 + k];
         exp_mem[exp_nrec % 64] = rec;
         exp_nrec++;
         exp_good++;
         last_rec = rec;
      end else if (res == BAD) begin
         exp_bad++;
         exp_drop++;
      end
   endtask

   task automatic send(input int first, input int last_excl, input int bad_beat);
      int n, nbeats, waited;
      n      = frm.size();
      nbeats = (n + 3) / 4;
      for (int b = first; b < last_excl; b++) begin
         RvviAxiRdata = '0;
         RvviAxiRstrb = '0;
         for (int l = 0; l < 4; l++) begin
            if (4*b + l < n) begin
               RvviAxiRdata[8*l +: 8] = frm[4*b + l];
               RvviAxiRstrb[l]        = 1'b1;
            end
         end
         if (b == bad_beat) RvviAxiRstrb = 4'b0011;
         RvviAxiRlast  = (b == nbeats - 1);
         RvviAxiRvalid = 1'b1;
         waited        = 0;
         forever begin
            @(negedge clk);
            if (RvviAxiRready) break;
            waited++;
            if (waited > 500) begin
               check("ready_timeout", RW'(RvviAxiRready), RW'(1));
               RvviAxiRvalid = 1'b0;
               RvviAxiRlast  = 1'b0;
               return;
            end
         end
         @(posedge clk);
         #1;
      end
      RvviAxiRvalid = 1'b0;
      RvviAxiRlast  = 1'b0;
   endtask

   task automatic verify(input string tag);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("%s_good", tag), RW'(GoodFrames), RW'(exp_good));
      check($sformatf("%s_bad", tag), RW'(BadFrames), RW'(exp_bad));
      check($sformatf("%s_drops", tag), RW'(drop_cnt), RW'(exp_drop));
      check($sformatf("%s_nrec", tag), RW'(rec_wr), RW'(exp_nrec));
      while (rec_rd < rec_wr && rec_rd < exp_nrec) begin
         check($sformatf("%s_rec%0d", tag, rec_rd), rec_mem[rec_rd % 64], exp_mem[rec_rd % 64]);
         rec_rd++;
      end
   endtask

   initial begin
      int viol, nb;
      s_axi_aresetn = 1'b0;
      RvviAxiRdata  = '0;
      RvviAxiRstrb  = '0;
      RvviAxiRlast  = 1'b0;
      RvviAxiRvalid = 1'b0;
      ready         = 1'b1;
      #12;
      check("rst_valid", RW'(valid), RW'(0));
      check("rst_rready", RW'(RvviAxiRready), RW'(1));
      check("rst_good", RW'(GoodFrames), RW'(0));
      check("rst_bad", RW'(BadFrames), RW'(0));
      check("rst_drop", RW'(FrameDrop), RW'(0));
      check("rst_rvvi", rvvi, '0);
      @(negedge clk) s_axi_aresetn = 1'b1;
      @(posedge clk); #1;

      // 1: 113-byte good frame, valid one cycle after Rlast
      gen(113, 0); model_frame(-1);
      send(0, 29, -1);
      check("s1_valid_rise", RW'(valid), RW'(1));
      check("s1_rvvi", rvvi, last_rec);
      verify("s1");

      // 2: trigger frame is dropped silently
      gen(32, 1); model_frame(-1);
      send(0, 8, -1);
      verify("s2");

      // 3: short matching frame; presented record untouched
      gen(60, 0); model_frame(-1);
      send(0, 15, -1);
      verify("s3");
      check("s3_rvvi_kept", rvvi, last_rec);

      // 4: consumer stalls with a second frame queued
      ready = 1'b0;
      gen(113, 0); model_frame(-1);
      send(0, 29, -1);
      check("s4_valid", RW'(valid), RW'(1));
      check("s4_rvvi", rvvi, last_rec);
      snap = rvvi;
      viol = 0;
      gen(120, 0); model_frame(-1);
      nb = (frm.size() + 3) / 4;
      fork
         send(0, nb, -1);
         begin
            repeat (50) begin
               @(negedge clk);
               if (RvviAxiRready !== 1'b0) viol++;
               if (rvvi !== snap) viol++;
               if (valid !== 1'b1) viol++;
            end
            @(posedge clk); #1;
            ready = 1'b1;
         end
      join
      check("s4_hold_stable", RW'(viol), RW'(0));
      verify("s4");

      // 5: illegal strobe mid-frame, then a good frame
      gen(113, 0); model_frame(10);
      send(0, 29, 10);
      gen(116, 0); model_frame(-1);
      send(0, 29, -1);
      verify("s5");

      // 6: reset mid-frame; the tail is parsed as a new frame
      gen(113, 0);
      send(0, 15, -1);
      s_axi_aresetn = 1'b0;
      #1;
      check("s6_valid", RW'(valid), RW'(0));
      check("s6_rready", RW'(RvviAxiRready), RW'(1));
      check("s6_good", RW'(GoodFrames), RW'(0));
      check("s6_bad", RW'(BadFrames), RW'(0));
      check("s6_drop", RW'(FrameDrop), RW'(0));
      check("s6_rvvi", rvvi, '0);
      exp_good = 0;
      exp_bad  = 0;
      last_rec = '0;
      @(negedge clk) s_axi_aresetn = 1'b1;
      @(posedge clk); #1;
      frm = frm[60:$];
      model_frame(-1);
      send(0, (frm.size() + 3) / 4, -1);
      gen(113, 0); model_frame(-1);
      send(0, 29, -1);
      verify("s6");

      // randomized frames of mixed length and type
      for (int i = 0; i < 12; i++) begin
         gen($urandom_range(1, 140), ($urandom_range(0, 3) != 0) ? 0 : 2);
         model_frame(-1);
         send(0, (frm.size() + 3) / 4, -1);
         verify($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
